// File: rtl/dccm_arb_pkg.sv
// dccm_arb_pkg
// Shared definitions for the DCCM arbiter/AXI bridge:
//   - NUM_REQ        : number of requester ports (LSU = 0, DMA = 1)
//   - AXI_* constants: single-beat INCR bursts of one 32-bit word
//   - state_e        : controller FSM states
// Optional feature macro used by the arbiter: DCCM_ARB_RR_EN
package dccm_arb_pkg;

  localparam int NUM_REQ = 2;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [7:0] AXI_LEN_1BEAT  = 8'd0;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_AW_W = 3'd3,
    WR_RESP = 3'd4,
    RESP    = 3'd5
  } state_e;

endpackage

// File: rtl/dccm_arb_rr.sv
// dccm_arb_rr
// Two-way request arbiter for the DCCM controller.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset (pointer favours port 0)
//   req_i     : request valid per port
//   accept_i  : the current grant was accepted this cycle
//   gnt_o     : one-hot grant (all zero when nobody requests)
//   gnt_idx_o : index of the winning port
// Macro DCCM_ARB_RR_EN: defined -> round-robin, undefined -> port 0 has
// fixed priority.
module dccm_arb_rr
  import dccm_arb_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               accept_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               gnt_idx_o
);

`ifdef DCCM_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  logic ptr_q, ptr_d;
  logic favour;

  // In fixed-priority builds the pointer is masked off so port 0 is always
  // favoured; the register then carries no function and trims away.
  assign favour = RR_EN & ptr_q;

  // The favoured port wins if it requests, otherwise the other one does.
  always_comb begin
    gnt_idx_o          = req_i[favour] ? favour : ~favour;
    gnt_o              = '0;
    gnt_o[gnt_idx_o]   = req_i[gnt_idx_o];
  end

  // After an accept, favour the port that did not just win.
  assign ptr_d = accept_i ? ~gnt_idx_o : ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dccm_arb_ctrl.sv
// dccm_arb_ctrl
// Arbitrates an LSU port (0) and a DMA port (1) onto a single AXI4 master
// that talks to the DCCM, one single-beat transaction at a time.
//   s_aclk / s_areset        : clock, synchronous active-high reset
//   req_* (per port)         : valid/ready request with we/addr/wdata/wstrb
//   rsp_valid (per port)     : one-cycle response pulse
//   rsp_rdata / rsp_err      : shared response payload
//   mem_busy                 : memory still in reset, blocks new accepts
//   m_axi_*                  : AXI4 master (AR, AW, W, R, B channels)
// Macro DCCM_ARB_RR_EN selects round-robin arbitration (see dccm_arb_rr).
module dccm_arb_ctrl
  import dccm_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4,
  parameter int DCCM_BYTES = 65536
) (
  input  logic                              s_aclk,
  input  logic                              s_areset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0]                req_we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_wdata,
  input  logic [NUM_REQ-1:0][DATA_W/8-1:0]  req_wstrb,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [DATA_W-1:0]                 rsp_rdata,
  output logic                              rsp_err,
  input  logic                              mem_busy,
  output logic [ADDR_W-1:0]                 m_axi_araddr,
  output logic [1:0]                        m_axi_arburst,
  output logic [ID_W-1:0]                   m_axi_arid,
  output logic [7:0]                        m_axi_arlen,
  output logic [2:0]                        m_axi_arsize,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  output logic [ADDR_W-1:0]                 m_axi_awaddr,
  output logic [1:0]                        m_axi_awburst,
  output logic [ID_W-1:0]                   m_axi_awid,
  output logic [7:0]                        m_axi_awlen,
  output logic [2:0]                        m_axi_awsize,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [DATA_W-1:0]                 m_axi_wdata,
  output logic [DATA_W/8-1:0]               m_axi_wstrb,
  output logic                              m_axi_wlast,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [DATA_W-1:0]                 m_axi_rdata,
  input  logic [ID_W-1:0]                   m_axi_rid,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rlast,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready,
  input  logic [ID_W-1:0]                   m_axi_bid,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W:0] DCCM_LIMIT = (ADDR_W+1)'(DCCM_BYTES);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                we_q, we_d;
  logic                gnt_q, gnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic                arb_idx;
  logic                can_accept, accept;
  logic [ADDR_W-1:0]   sel_addr;
  logic                addr_bad;
  logic                in_resp;
  logic                aw_hs, w_hs, ar_hs;
  logic                unused_axi;

  // IDs and the low response bit carry no information for a single
  // outstanding transaction with OKAY/SLVERR-only error reporting.
  assign unused_axi = ^{m_axi_rid, m_axi_bid, m_axi_rresp[0], m_axi_bresp[0]};

  // Ready is offered only to the current winner, only in IDLE, and never
  // while the memory or this block is in reset.
  assign can_accept = (state_q == IDLE) && !mem_busy && !s_areset;
  assign req_ready  = can_accept ? arb_gnt : '0;
  assign accept     = |req_ready;

  dccm_arb_rr u_arb (
    .clk_i     (s_aclk),
    .rst_i     (s_areset),
    .req_i     (req_valid),
    .accept_i  (accept),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  // Out-of-range or misaligned accesses are answered locally with an error.
  assign sel_addr = req_addr[arb_idx];
  assign addr_bad = ({1'b0, sel_addr} >= DCCM_LIMIT) || (sel_addr[1:0] != 2'b00);

  assign ar_hs = m_axi_arvalid & m_axi_arready;
  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid  & m_axi_wready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    we_d      = we_q;
    gnt_d     = gnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d    = sel_addr;
          wdata_d   = req_wdata[arb_idx];
          wstrb_d   = req_wstrb[arb_idx];
          we_d      = req_we[arb_idx];
          gnt_d     = arb_idx;
          rdata_d   = '0;
          err_d     = addr_bad;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (addr_bad)                 state_d = RESP;
          else if (req_we[arb_idx])     state_d = WR_AW_W;
          else                          state_d = RD_ADDR;
        end
      end
      RD_ADDR: if (ar_hs) state_d = RD_DATA;
      RD_DATA: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          err_d   = m_axi_rresp[1] | ~m_axi_rlast;
          state_d = RESP;
        end
      end
      WR_AW_W: begin
        // AW and W complete independently; move on once both are done.
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          err_d   = m_axi_bresp[1];
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_aclk) begin
    if (s_areset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
      gnt_q     <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      we_q      <= we_d;
      gnt_q     <= gnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // AXI fields are fixed for single-beat word accesses; valids and readys
  // are also gated by reset so nothing is driven while it is asserted.
  assign m_axi_araddr  = addr_q;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arid    = ID_W'(gnt_q);
  assign m_axi_arlen   = AXI_LEN_1BEAT;
  assign m_axi_arsize  = AXI_SIZE_4B;
  assign m_axi_arvalid = !s_areset && (state_q == RD_ADDR);

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awid    = ID_W'(gnt_q);
  assign m_axi_awlen   = AXI_LEN_1BEAT;
  assign m_axi_awsize  = AXI_SIZE_4B;
  assign m_axi_awvalid = !s_areset && (state_q == WR_AW_W) && !aw_done_q;

  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_wvalid  = !s_areset && (state_q == WR_AW_W) && !w_done_q;

  assign m_axi_rready  = !s_areset && (state_q == RD_DATA);
  assign m_axi_bready  = !s_areset && (state_q == WR_RESP);

  // Response pulse goes only to the granted port; write responses carry
  // zero data.
  assign in_resp = !s_areset && (state_q == RESP);

  always_comb begin
    rsp_valid = '0;
    if (in_resp) rsp_valid[gnt_q] = 1'b1;
  end

  assign rsp_rdata = (in_resp && !we_q) ? rdata_q : '0;
  assign rsp_err   = in_resp & err_q;

endmodule

// File: tb/tb_dccm_arb_ctrl.sv
`timescale 1ns/1ps
module tb_dccm_arb_ctrl;
  import dccm_arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]             req_valid = '0;
  logic [1:0]             req_ready;
  logic [1:0]             req_we = '0;
  logic [1:0][ADDR_W-1:0] req_addr = '0;
  logic [1:0][DATA_W-1:0] req_wdata = '0;
  logic [1:0][3:0]        req_wstrb = '0;
  logic [1:0]             rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;
  logic                   memBusy = 1'b0;

  logic [ADDR_W-1:0] m_axi_araddr, m_axi_awaddr;
  logic [1:0]        m_axi_arburst, m_axi_awburst;
  logic [ID_W-1:0]   m_axi_arid, m_axi_awid;
  logic [7:0]        m_axi_arlen, m_axi_awlen;
  logic [2:0]        m_axi_arsize, m_axi_awsize;
  logic              m_axi_arvalid, m_axi_awvalid, m_axi_arready, m_axi_awready;
  logic [DATA_W-1:0] m_axi_wdata;
  logic [3:0]        m_axi_wstrb;
  logic              m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [DATA_W-1:0] m_axi_rdata = '0;
  logic [ID_W-1:0]   m_axi_rid = '0;
  logic [1:0]        m_axi_rresp = '0;
  logic              m_axi_rlast = 1'b0, m_axi_rvalid = 1'b0, m_axi_rready;
  logic [ID_W-1:0]   m_axi_bid = '0;
  logic [1:0]        m_axi_bresp = '0;
  logic              m_axi_bvalid = 1'b0, m_axi_bready;

  dccm_arb_ctrl dut (
    .s_aclk(clk), .s_areset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_busy(memBusy),
    .m_axi_araddr(m_axi_araddr), .m_axi_arburst(m_axi_arburst), .m_axi_arid(m_axi_arid),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awburst(m_axi_awburst), .m_axi_awid(m_axi_awid),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rid(m_axi_rid), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  // Bookkeeping shared by every check in the bench.
  int testsRun = 0;
  int failCount = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Expected responses, pushed when a request is accepted.
  typedef struct {
    int          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    bit          err;
  } sbEntry_t;
  sbEntry_t sbq[$];

  // Zero-wait AXI slave backed by a small word memory, with knobs for
  // W-channel stalls, error responses, missing RLAST and dropped reads.
  logic [31:0] slvMem [0:1023];
  int  arCount = 0, awCount = 0, wCount = 0;
  int  wWait = 0, wStall = 0;
  bit  rHold = 0, slvRespErr = 0, slvNoLast = 0;
  logic awGot = 0, wGot = 0;
  logic [31:0] awAddrS = '0, wDataS = '0, tA, tD;
  logic [3:0]  wStrbS = '0, tS;
  logic [ID_W-1:0] awIdS = '0;

  assign m_axi_arready = 1'b1;
  assign m_axi_awready = 1'b1;
  assign m_axi_wready  = (wWait >= wStall);

  initial for (int i = 0; i < 1024; i++) slvMem[i] = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_axi_rvalid <= 1'b0;
      m_axi_bvalid <= 1'b0;
      awGot <= 1'b0;
      wGot  <= 1'b0;
      wWait <= 0;
    end else begin
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) begin
        arCount <= arCount + 1;
        if (!rHold) begin
          m_axi_rvalid <= 1'b1;
          m_axi_rdata  <= slvMem[m_axi_araddr[11:2]];
          m_axi_rid    <= m_axi_arid;
          m_axi_rresp  <= slvRespErr ? 2'b10 : 2'b00;
          m_axi_rlast  <= !slvNoLast;
        end
      end
      if (m_axi_awvalid && m_axi_awready) begin
        awCount <= awCount + 1;
        awGot   <= 1'b1;
        awAddrS <= m_axi_awaddr;
        awIdS   <= m_axi_awid;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        wCount <= wCount + 1;
        wGot   <= 1'b1;
        wDataS <= m_axi_wdata;
        wStrbS <= m_axi_wstrb;
        wWait  <= 0;
      end else if (m_axi_wvalid) begin
        wWait <= wWait + 1;
      end
      if ((awGot || (m_axi_awvalid && m_axi_awready)) &&
          (wGot || (m_axi_wvalid && m_axi_wready)) && !m_axi_bvalid) begin
        tA = (m_axi_awvalid && m_axi_awready) ? m_axi_awaddr : awAddrS;
        tD = (m_axi_wvalid && m_axi_wready) ? m_axi_wdata : wDataS;
        tS = (m_axi_wvalid && m_axi_wready) ? m_axi_wstrb : wStrbS;
        for (int b = 0; b < 4; b++)
          if (tS[b]) slvMem[tA[11:2]][8*b +: 8] <= tD[8*b +: 8];
        m_axi_bvalid <= 1'b1;
        m_axi_bid    <= (m_axi_awvalid && m_axi_awready) ? m_axi_awid : awIdS;
        m_axi_bresp  <= slvRespErr ? 2'b10 : 2'b00;
        awGot <= 1'b0;
        wGot  <= 1'b0;
      end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
    end
  end

  // Monitor: checks AXI beat fields against the pending scoreboard entry and
  // pops one entry per response pulse.
  logic [1:0] prevRsp = '0;
  always @(negedge clk) begin
    sbEntry_t e;
    if (rst) begin
      prevRsp = '0;
    end else begin
      if (m_axi_arvalid) begin
        checkOutput("arlen", m_axi_arlen, 0);
        checkOutput("arsize", m_axi_arsize, 3'd2);
        checkOutput("arburst", m_axi_arburst, 2'b01);
        checkOutput("ar has pending request", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          checkOutput("arid", m_axi_arid, sbq[0].port);
          checkOutput("araddr", m_axi_araddr, sbq[0].addr);
        end
      end
      if (m_axi_awvalid) begin
        checkOutput("awlen", m_axi_awlen, 0);
        checkOutput("awsize", m_axi_awsize, 3'd2);
        checkOutput("awburst", m_axi_awburst, 2'b01);
        checkOutput("aw has pending request", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          checkOutput("awid", m_axi_awid, sbq[0].port);
          checkOutput("awaddr", m_axi_awaddr, sbq[0].addr);
        end
      end
      if (m_axi_wvalid) begin
        checkOutput("wlast", m_axi_wlast, 1);
        if (sbq.size() != 0) begin
          checkOutput("wdata", m_axi_wdata, sbq[0].wdata);
          checkOutput("wstrb", m_axi_wstrb, sbq[0].strb);
        end
      end
      if (rsp_valid != 0) begin
        checkOutput("rsp one-hot", $countones(rsp_valid), 1);
        checkOutput("rsp single pulse", rsp_valid & prevRsp, 0);
        checkOutput("rsp expected", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          checkOutput("rsp port", rsp_valid, 2'b01 << e.port);
          checkOutput("rsp rdata", rsp_rdata, e.rdata);
          checkOutput("rsp err", rsp_err, e.err);
        end
      end
      prevRsp = rsp_valid;
    end
  end

  // Drive one request on port p, hold it until accepted (bounded), and push
  // the expected response. Returns just after the accept edge.
  task automatic applyStimulus(input int p, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input logic [31:0] expRdata, input bit expErr);
    bit accepted = 0;
    req_valid[p] = 1'b1;
    req_we[p]    = we;
    req_addr[p]  = addr;
    req_wdata[p] = wdata;
    req_wstrb[p] = strb;
    for (int cyc = 0; cyc < 50 && !accepted; cyc++) begin
      @(negedge clk);
      if (req_ready[p]) begin
        accepted = 1;
        sbq.push_back('{p, we, addr, wdata, strb, expRdata, expErr});
      end
      @(posedge clk); #1;
    end
    req_valid[p] = 1'b0;
    checkOutput($sformatf("accept port %0d", p), accepted, 1);
  endtask

  // Count edges from the accept edge to the edge that samples rsp_valid[p].
  task automatic waitRsp(input int p, output int lat);
    bit seen = 0;
    lat = 1;
    for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
      @(negedge clk);
      if (rsp_valid[p]) seen = 1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    if (seen) begin
      @(posedge clk); #1;
    end
    checkOutput($sformatf("rsp seen port %0d", p), seen, 1);
  endtask

  typedef struct {
    int          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          injErr;
    bit          injNoLast;
    logic [31:0] expRdata;
    bit          expErr;
    int          expLat;
  } vec_t;

  vec_t vecs[15];
  logic [1:0] expGnt[4];

  initial begin
    int lat, traf, nGnt, gotRd;
    int awBefore, wBefore;

    vecs[0]  = '{0, 1, 32'h10,    32'hDEADBEEF, 4'hF, 0, 0, 32'h0,        0, 3};
    vecs[1]  = '{0, 0, 32'h10,    32'h0,        4'h0, 0, 0, 32'hDEADBEEF, 0, 3};
    vecs[2]  = '{1, 1, 32'h20,    32'h12345678, 4'hF, 0, 0, 32'h0,        0, 3};
    vecs[3]  = '{1, 0, 32'h20,    32'h0,        4'h0, 0, 0, 32'h12345678, 0, 3};
    vecs[4]  = '{0, 1, 32'h20,    32'h0000AB00, 4'h2, 0, 0, 32'h0,        0, 3};
    vecs[5]  = '{1, 0, 32'h20,    32'h0,        4'h0, 0, 0, 32'h1234AB78, 0, 3};
    vecs[6]  = '{0, 0, 32'h10000, 32'h0,        4'h0, 0, 0, 32'h0,        1, 1};
    vecs[7]  = '{1, 0, 32'h3,     32'h0,        4'h0, 0, 0, 32'h0,        1, 1};
    vecs[8]  = '{0, 1, 32'h10002, 32'h55555555, 4'hF, 0, 0, 32'h0,        1, 1};
    vecs[9]  = '{1, 1, 32'hFFFC,  32'hCAFEF00D, 4'hF, 0, 0, 32'h0,        0, 3};
    vecs[10] = '{0, 0, 32'hFFFC,  32'h0,        4'h0, 0, 0, 32'hCAFEF00D, 0, 3};
    vecs[11] = '{0, 1, 32'h8,     32'h11111111, 4'hF, 1, 0, 32'h0,        1, 3};
    vecs[12] = '{1, 0, 32'h10,    32'h0,        4'h0, 1, 0, 32'hDEADBEEF, 1, 3};
    vecs[13] = '{0, 0, 32'h10,    32'h0,        4'h0, 0, 1, 32'hDEADBEEF, 1, 3};
    vecs[14] = '{0, 0, 32'h4,     32'h0,        4'h0, 0, 0, 32'h0,        0, 3};

`ifdef DCCM_ARB_RR_EN
    expGnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    expGnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

    // Reset state, with both requesters already asking.
    rst = 1'b1;
    req_valid = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset req_ready", req_ready, 0);
    checkOutput("reset rsp_valid", rsp_valid, 0);
    checkOutput("reset rsp_rdata", rsp_rdata, 0);
    checkOutput("reset rsp_err", rsp_err, 0);
    checkOutput("reset axi valids",
                {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 0);
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;

    // Table of single transactions.
    foreach (vecs[i]) begin
      slvRespErr = vecs[i].injErr;
      slvNoLast  = vecs[i].injNoLast;
      traf = arCount + awCount + wCount;
      applyStimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                    vecs[i].expRdata, vecs[i].expErr);
      waitRsp(vecs[i].port, lat);
      checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].expLat);
      checkOutput($sformatf("vec%0d axi beats", i), arCount + awCount + wCount - traf,
                  vecs[i].expErr && vecs[i].expLat == 1 ? 0 : (vecs[i].we ? 2 : 1));
      slvRespErr = 0;
      slvNoLast  = 0;
    end

    // mem_busy blocks ready; accept follows in the cycle it falls.
    memBusy = 1'b1;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("busy blocks ready %0d", k), req_ready, 0);
      @(posedge clk); #1;
    end
    memBusy = 1'b0;
    @(negedge clk);
    checkOutput("ready when busy falls", req_ready, 2'b01);
    if (req_ready[0]) sbq.push_back('{0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0});
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    waitRsp(0, lat);
    checkOutput("busy read latency", lat, 3);

    // W stalled 5 cycles while AW is immediate.
    wStall = 5;
    awBefore = awCount; wBefore = wCount;
    applyStimulus(1, 1, 32'h30, 32'hA5A5A5A5, 4'hF, 32'h0, 0);
    waitRsp(1, lat);
    checkOutput("wstall aw beats", awCount - awBefore, 1);
    checkOutput("wstall w beats", wCount - wBefore, 1);
    checkOutput("wstall latency", lat, 8);
    wStall = 0;

    // Reset while waiting for read data.
    rHold = 1;
    applyStimulus(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0);
    gotRd = 0;
    for (int k = 0; k < 20 && gotRd == 0; k++) begin
      @(negedge clk);
      if (m_axi_rready) gotRd = 1;
    end
    checkOutput("reached RD_DATA", gotRd, 1);
    sbq.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rHold = 0;
    @(negedge clk);
    checkOutput("after reset axi valids",
                {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 0);
    checkOutput("after reset rsp_valid", rsp_valid, 0);
    repeat (4) @(posedge clk);
    #1;
    applyStimulus(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0);
    waitRsp(0, lat);
    checkOutput("post-reset read latency", lat, 3);

    // Both ports request reads continuously from a fresh pointer.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    req_we = 2'b00;
    req_addr[0] = 32'h10;
    req_addr[1] = 32'h20;
    req_valid = 2'b11;
    nGnt = 0;
    for (int cyc = 0; cyc < 200 && nGnt < 4; cyc++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        checkOutput($sformatf("grant %0d", nGnt), req_ready, expGnt[nGnt]);
        if (expGnt[nGnt] == 2'b01)
          sbq.push_back('{0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0});
        else
          sbq.push_back('{1, 0, 32'h20, 32'h0, 4'h0, 32'h1234AB78, 0});
        nGnt++;
      end
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    checkOutput("arb grant count", nGnt, 4);
    for (int cyc = 0; cyc < 50 && sbq.size() != 0; cyc++) @(negedge clk);
    checkOutput("arb drained", sbq.size(), 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
